// File: rtl/jt12_pkg.sv
// Shared definitions for the JT12 operator control slice: field widths,
// the 44-bit operator register layout, operator order and channel codes.
package jt12_pkg;

  localparam int TL_W   = 7;
  localparam int DT1_W  = 3;
  localparam int MUL_W  = 4;
  localparam int KS_W   = 2;
  localparam int AR_W   = 5;
  localparam int D1R_W  = 5;
  localparam int D2R_W  = 5;
  localparam int SL_W   = 4;
  localparam int RR_W   = 4;
  localparam int SSG_W  = 3;
  localparam int OP_W   = 44;

  // Operator register layout, MSB first
  typedef struct packed {
    logic [TL_W-1:0]  tl;
    logic [DT1_W-1:0] dt1;
    logic [MUL_W-1:0] mul;
    logic [KS_W-1:0]  ks;
    logic [AR_W-1:0]  ar;
    logic             amsen;
    logic [D1R_W-1:0] d1r;
    logic [D2R_W-1:0] d2r;
    logic [SL_W-1:0]  sl;
    logic [RR_W-1:0]  rr;
    logic             ssg_en;
    logic [SSG_W-1:0] ssg_eg;
  } op_regs_t;

  // Operator order as presented on next_op
  localparam logic [1:0] OP_S1 = 2'd0;
  localparam logic [1:0] OP_S3 = 2'd1;
  localparam logic [1:0] OP_S2 = 2'd2;
  localparam logic [1:0] OP_S4 = 2'd3;

  // Channel codes that never address a channel
  localparam logic [2:0] CH_INV_A = 3'd3;
  localparam logic [2:0] CH_INV_B = 3'd7;
  localparam logic [2:0] CSM_CH   = 3'd2;

  // True when a channel code addresses an existing channel
  function automatic logic ch_valid(input logic [2:0] ch, input int num_ch);
    logic ok;
    ok = 1'b1;
    if (ch == CH_INV_A || ch == CH_INV_B) ok = 1'b0;
    if (num_ch == 3 && ch >= 3'd4) ok = 1'b0;
    return ok;
  endfunction

  // Picks the key-on mask bit (din[7:4]) belonging to an operator code
  function automatic logic kon_mask_bit(input logic [3:0] mask, input logic [1:0] op);
    logic b;
    case (op)
      OP_S1:   b = mask[0];
      OP_S2:   b = mask[1];
      OP_S3:   b = mask[2];
      default: b = mask[3];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/jt12_op_sh.sv
// Circular-store building block: W bits x STAGES shift register that
// advances only on clk_en; async active-low reset to RST_VAL.
module jt12_op_sh #(
  parameter int             W       = 1,
  parameter int             STAGES  = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] drop
);

  genvar gi;

  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [W-1:0] q_reg;
      logic [W-1:0] d;

      if (gi == 0) begin : g_first
        assign d = din;
      end else begin : g_rest
        assign d = g_stage[gi-1].q_reg;
      end

      // One pipeline stage, held while clk_en is low
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          q_reg <= RST_VAL;
        end else if (clk_en) begin
          q_reg <= d;
        end
      end
    end
  endgenerate

  assign drop = g_stage[STAGES-1].q_reg;

endmodule

// File: rtl/jt12_op_ctrl.sv
// JT12 operator control: per-slot operator register store, key-on store
// and modulator input routing. Optional CSM key-on under JT12_CSM_EN.
module jt12_op_ctrl
  import jt12_pkg::*;
#(
  parameter int NUM_CH = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  logic [7:0]      din,
  input  logic            up_dt1,
  input  logic            up_tl,
  input  logic            up_ks_ar,
  input  logic            up_amen_dr,
  input  logic            up_sr,
  input  logic            up_sl_rr,
  input  logic            up_ssgeg,
  input  logic            update_op_I,
  input  logic            update_op_II,
  input  logic            update_op_IV,
  input  logic            up_keyon,
  input  logic [1:0]      next_op,
  input  logic [2:0]      next_ch,
  input  logic            csm,
  input  logic            overflow_A,
  input  logic [2:0]      alg_I,
  input  logic            s1_enters,
  input  logic            s2_enters,
  input  logic            s3_enters,
  input  logic            s4_enters,
  output logic [OP_W-1:0] op_regs,
  output logic            keyon_I,
  output logic            use_prevprev1,
  output logic            use_internal_x,
  output logic            use_internal_y,
  output logic            use_prev2,
  output logic            use_prev1
);

  localparam int SLOTS = 4 * NUM_CH;

  op_regs_t op_last;
  op_regs_t op_next;
  logic     kon_last;
  logic     kon_next;
  logic     csm_force;

  // Operator register ring; the slot leaving the ring re-enters with edits
  jt12_op_sh #(
    .W      (OP_W),
    .STAGES (SLOTS),
    .RST_VAL('0)
  ) u_op_sh (
    .clk   (clk),
    .rst   (rst),
    .clk_en(clk_en),
    .din   (op_next),
    .drop  (op_last)
  );

  assign op_regs = op_last;

  // Field replacement: each write strobe is qualified by its stage select
  always_comb begin
    op_next = op_last;
    if (update_op_I) begin
      if (up_dt1)     op_next.dt1 = din[6:4];
      if (up_ks_ar)   op_next.ar  = din[4:0];
      if (up_amen_dr) op_next.d1r = din[4:0];
      if (up_sr)      op_next.d2r = din[4:0];
      if (up_sl_rr) begin
        op_next.sl = din[7:4];
        op_next.rr = din[3:0];
      end
      if (up_ssgeg) begin
        op_next.ssg_en = din[3];
        op_next.ssg_eg = din[2:0];
      end
    end
    if (update_op_II) begin
      if (up_dt1)   op_next.mul = din[3:0];
      if (up_ks_ar) op_next.ks  = din[7:6];
    end
    if (update_op_IV) begin
      if (up_tl)      op_next.tl    = din[6:0];
      if (up_amen_dr) op_next.amsen = din[7];
    end
  end

`ifdef JT12_CSM_EN
  assign csm_force = csm & overflow_A & (next_ch == CSM_CH);
`else
  logic unused_csm;
  assign csm_force  = 1'b0;
  assign unused_csm = csm ^ overflow_A;
`endif

  // Key-on ring; one bit per slot, in step with next_op/next_ch
  jt12_op_sh #(
    .W      (1),
    .STAGES (SLOTS),
    .RST_VAL(1'b0)
  ) u_kon_sh (
    .clk   (clk),
    .rst   (rst),
    .clk_en(clk_en),
    .din   (kon_next),
    .drop  (kon_last)
  );

  // Key-on bit update: CPU write for the addressed channel, CSM overrides it
  always_comb begin
    kon_next = kon_last;
    if (up_keyon && ch_valid(din[2:0], NUM_CH) && (next_ch == din[2:0])) begin
      kon_next = kon_mask_bit(din[7:4], next_op);
    end
    if (csm_force) begin
      kon_next = 1'b1;
    end
  end

  // Registered key-on of the slot just presented
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keyon_I <= 1'b0;
    end else if (clk_en) begin
      keyon_I <= kon_next;
    end
  end

  // Modulator input routing for the operator currently entering
  always_comb begin
    use_prevprev1  = 1'b0;
    use_internal_x = 1'b0;
    use_internal_y = 1'b0;
    use_prev2      = 1'b0;
    use_prev1      = 1'b0;
    if (s1_enters) begin
      use_prevprev1 = 1'b1;
      use_prev1     = 1'b1;
    end
    if (s3_enters) begin
      if (alg_I == 3'd5)  use_prevprev1 = 1'b1;
      if (alg_I <= 3'd2)  use_prev2     = 1'b1;
      if (alg_I == 3'd1)  use_prev1     = 1'b1;
    end
    if (s2_enters) begin
      case (alg_I)
        3'd0, 3'd3, 3'd4, 3'd5, 3'd6: use_prev1 = 1'b1;
        default: ;
      endcase
    end
    if (s4_enters) begin
      if (alg_I == 3'd3)                   use_prev2      = 1'b1;
      if (alg_I == 3'd2)                   use_internal_x = 1'b1;
      if (alg_I <= 3'd1)                   use_internal_y = 1'b1;
      if (alg_I == 3'd0 || alg_I == 3'd5)  use_prev1      = 1'b1;
    end
  end

endmodule

// File: tb/tb_jt12_op_ctrl.sv
// Self-checking bench for jt12_op_ctrl: directed scenarios followed by
// randomized traffic, checked against a slot-array reference model.
module tb_jt12_op_ctrl;

  localparam int NUM_CH = 6;
  localparam int N      = 4 * NUM_CH;

`ifdef JT12_CSM_EN
  localparam bit CSM_ON = 1'b1;
`else
  localparam bit CSM_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic [7:0]  din;
  logic        up_dt1, up_tl, up_ks_ar, up_amen_dr, up_sr, up_sl_rr, up_ssgeg;
  logic        update_op_I, update_op_II, update_op_IV;
  logic        up_keyon;
  logic [1:0]  next_op;
  logic [2:0]  next_ch;
  logic        csm, overflow_A;
  logic [2:0]  alg_I;
  logic        s1_enters, s2_enters, s3_enters, s4_enters;
  logic [43:0] op_regs;
  logic        keyon_I;
  logic        use_prevprev1, use_internal_x, use_internal_y, use_prev2, use_prev1;

  jt12_op_ctrl #(.NUM_CH(NUM_CH)) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .din           (din),
    .up_dt1        (up_dt1),
    .up_tl         (up_tl),
    .up_ks_ar      (up_ks_ar),
    .up_amen_dr    (up_amen_dr),
    .up_sr         (up_sr),
    .up_sl_rr      (up_sl_rr),
    .up_ssgeg      (up_ssgeg),
    .update_op_I   (update_op_I),
    .update_op_II  (update_op_II),
    .update_op_IV  (update_op_IV),
    .up_keyon      (up_keyon),
    .next_op       (next_op),
    .next_ch       (next_ch),
    .csm           (csm),
    .overflow_A    (overflow_A),
    .alg_I         (alg_I),
    .s1_enters     (s1_enters),
    .s2_enters     (s2_enters),
    .s3_enters     (s3_enters),
    .s4_enters     (s4_enters),
    .op_regs       (op_regs),
    .keyon_I       (keyon_I),
    .use_prevprev1 (use_prevprev1),
    .use_internal_x(use_internal_x),
    .use_internal_y(use_internal_y),
    .use_prev2     (use_prev2),
    .use_prev1     (use_prev1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain per-slot field records and a key-on table
  typedef struct {
    logic [6:0] tl;
    logic [2:0] dt1;
    logic [3:0] mul;
    logic [1:0] ks;
    logic [4:0] ar;
    logic       amsen;
    logic [4:0] d1r;
    logic [4:0] d2r;
    logic [3:0] sl;
    logic [3:0] rr;
    logic       ssg_en;
    logic [2:0] ssg_eg;
  } fields_t;

  fields_t opm [N];
  logic    konm [4][8];
  int      p;
  logic    kon_exp;
  int      checks;
  int      failures;
  logic    last_kon;
  logic [2:0] last_ch;
  int      op_bit [4] = '{4, 6, 5, 7};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [43:0] pack(input fields_t f);
    return {f.tl, f.dt1, f.mul, f.ks, f.ar, f.amsen, f.d1r, f.d2r,
            f.sl, f.rr, f.ssg_en, f.ssg_eg};
  endfunction

  function automatic fields_t zero_fields();
    fields_t f;
    f.tl = '0; f.dt1 = '0; f.mul = '0; f.ks = '0; f.ar = '0; f.amsen = 1'b0;
    f.d1r = '0; f.d2r = '0; f.sl = '0; f.rr = '0; f.ssg_en = 1'b0; f.ssg_eg = '0;
    return f;
  endfunction

  // Slot s of the presentation order: op = s / NUM_CH, channel codes skip 3
  function automatic logic [2:0] ch_code(input int s);
    int c;
    c = s % NUM_CH;
    return (c < 3) ? 3'(c) : 3'(c + 1);
  endfunction

  function automatic logic [4:0] route_ref(input logic [2:0] a, input logic s1,
                                           input logic s2, input logic s3, input logic s4);
    logic pp1, ix, iy, p2, p1;
    int ai;
    ai  = int'(a);
    pp1 = s1 | (s3 & (ai == 5));
    p2  = (s3 & (ai <= 2)) | (s4 & (ai == 3));
    ix  = s4 & (ai == 2);
    iy  = s4 & (ai <= 1);
    p1  = s1 | (s3 & (ai == 1)) | (s2 & (ai == 0 || ai == 3 || ai == 4 || ai == 5 || ai == 6))
             | (s4 & (ai == 0 || ai == 5));
    return {pp1, ix, iy, p2, p1};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) opm[i] = zero_fields();
    for (int o = 0; o < 4; o++)
      for (int c = 0; c < 8; c++) konm[o][c] = 1'b0;
    p       = 0;
    kon_exp = 1'b0;
  endtask

  // One advancing cycle of the model, from the current TB inputs
  task automatic model_clk();
    int   op_i;
    logic [2:0] ch;
    logic nb;
    op_i = p / NUM_CH;
    ch   = ch_code(p);
    if (update_op_I && up_dt1)     opm[p].dt1 = din[6:4];
    if (update_op_I && up_ks_ar)   opm[p].ar  = din[4:0];
    if (update_op_I && up_amen_dr) opm[p].d1r = din[4:0];
    if (update_op_I && up_sr)      opm[p].d2r = din[4:0];
    if (update_op_I && up_sl_rr) begin opm[p].sl = din[7:4]; opm[p].rr = din[3:0]; end
    if (update_op_I && up_ssgeg) begin opm[p].ssg_en = din[3]; opm[p].ssg_eg = din[2:0]; end
    if (update_op_II && up_dt1)    opm[p].mul = din[3:0];
    if (update_op_II && up_ks_ar)  opm[p].ks  = din[7:6];
    if (update_op_IV && up_tl)     opm[p].tl  = din[6:0];
    if (update_op_IV && up_amen_dr) opm[p].amsen = din[7];
    nb = konm[op_i][ch];
    if (up_keyon && din[2:0] == ch && din[2:0] != 3'd3 && din[2:0] != 3'd7)
      nb = din[op_bit[op_i]];
    if (CSM_ON && csm && overflow_A && ch == 3'd2) nb = 1'b1;
    konm[op_i][ch] = nb;
    kon_exp = nb;
    p = (p + 1) % N;
  endtask

  task automatic idle();
    din = 8'h00; up_dt1 = 0; up_tl = 0; up_ks_ar = 0; up_amen_dr = 0; up_sr = 0;
    up_sl_rr = 0; up_ssgeg = 0; update_op_I = 0; update_op_II = 0; update_op_IV = 0;
    up_keyon = 0; csm = 0; overflow_A = 0;
  endtask

  // Present the next slot, clock once, check both stores on the falling edge
  task automatic step(input logic en);
    clk_en  = en;
    next_op = 2'(p / NUM_CH);
    next_ch = ch_code(p);
    last_ch = next_ch;
    @(posedge clk);
    if (rst && en) model_clk();
    @(negedge clk);
    check("op_regs", 64'(op_regs), 64'(pack(opm[p])));
    check("keyon_I", 64'(keyon_I), 64'(kon_exp));
    last_kon = keyon_I;
  endtask

  task automatic goto_slot(input int s);
    for (int k = 0; k < N && p != s; k++) step(1'b1);
    check("goto_slot", 64'(p), 64'(s));
  endtask

  task automatic route_check(input logic [2:0] a, input logic [3:0] s);
    alg_I = a;
    {s4_enters, s3_enters, s2_enters, s1_enters} = s;
    #1;
    check("route", 64'({use_prevprev1, use_internal_x, use_internal_y, use_prev2, use_prev1}),
          64'(route_ref(a, s[0], s[1], s[2], s[3])));
  endtask

  task automatic kon_pass(input string tag, input int want_ch, input logic want_val);
    for (int k = 0; k < N; k++) begin
      step(1'b1);
      check(tag, 64'(last_kon), 64'((int'(last_ch) == want_ch) ? want_val : 1'b0));
    end
  endtask

  task automatic mid_reset();
    rst = 1'b0;
    up_tl = 1; update_op_IV = 1; din = 8'h7F; up_keyon = 1;
    #1;
    check("rst_op_regs", 64'(op_regs), 64'd0);
    check("rst_keyon", 64'(keyon_I), 64'd0);
    model_reset();
    step(1'b1);
    step(1'b1);
    idle();
    rst = 1'b1;
  endtask

  initial begin
    fields_t e;
    checks = 0;
    failures = 0;
    idle();
    rst = 1'b0; clk_en = 1'b0; next_op = 0; next_ch = 0;
    alg_I = 0; s1_enters = 0; s2_enters = 0; s3_enters = 0; s4_enters = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_op_regs", 64'(op_regs), 64'd0);
    check("rst_keyon", 64'(keyon_I), 64'd0);

    // Routing sweep: every algorithm with each operator
    for (int a = 0; a < 8; a++)
      for (int s = 0; s < 4; s++) route_check(3'(a), 4'(1 << s));

    rst = 1'b1;

    // dt1/mul written to slot 0 in the same cycle
    up_dt1 = 1; din = 8'h57; update_op_I = 1; update_op_II = 1;
    step(1'b1);
    idle();
    repeat (N - 1) step(1'b1);
    e = zero_fields(); e.dt1 = 3'd5; e.mul = 4'd7;
    check("dt1_mul", 64'(op_regs), 64'(pack(e)));

    // sl/rr on slot 3, then an unselected write must not disturb it
    goto_slot(3);
    up_sl_rr = 1; din = 8'hA3; update_op_I = 1;
    step(1'b1);
    idle();
    goto_slot(3);
    up_sl_rr = 1; din = 8'h55; update_op_II = 1;
    step(1'b1);
    idle();
    goto_slot(3);
    e = zero_fields(); e.sl = 4'hA; e.rr = 4'h3;
    check("sl_rr", 64'(op_regs), 64'(pack(e)));

    // Key-on all four operators of channel 1, then off again
    up_keyon = 1; din = 8'hF1;
    repeat (N) step(1'b1);
    idle();
    kon_pass("kon_on_ch1", 1, 1'b1);
    up_keyon = 1; din = 8'h01;
    repeat (N) step(1'b1);
    idle();
    kon_pass("kon_off_ch1", 1, 1'b0);

    // Invalid channel code 3 is ignored
    up_keyon = 1; din = 8'hF3;
    repeat (N) step(1'b1);
    idle();
    kon_pass("kon_inv_ch", 3, 1'b0);

    // CSM forcing of channel 2
    csm = 1; overflow_A = 1;
    repeat (N) step(1'b1);
    idle();
    kon_pass("kon_csm_ch2", 2, CSM_ON);

    mid_reset();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      din          = 8'($urandom);
      up_dt1       = ($urandom_range(0, 3) == 0);
      up_tl        = ($urandom_range(0, 3) == 0);
      up_ks_ar     = ($urandom_range(0, 3) == 0);
      up_amen_dr   = ($urandom_range(0, 3) == 0);
      up_sr        = ($urandom_range(0, 3) == 0);
      up_sl_rr     = ($urandom_range(0, 3) == 0);
      up_ssgeg     = ($urandom_range(0, 3) == 0);
      update_op_I  = 1'($urandom);
      update_op_II = 1'($urandom);
      update_op_IV = 1'($urandom);
      up_keyon     = ($urandom_range(0, 7) == 0);
      csm          = ($urandom_range(0, 3) == 0);
      overflow_A   = ($urandom_range(0, 3) == 0);
      if ((i % 10) == 0) route_check(3'($urandom), 4'($urandom));
      step($urandom_range(0, 3) != 0);
      if (i == 1500) mid_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jt12_op_ctrl.md
JT12_OP_CTRL -- requirements
Module: jt12_op_ctrl

Interface
REQ-001 Parameter NUM_CH, default 6, number of FM channels (3 or 6); slot count 4*NUM_CH.
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 clk_en  in  1  advance enable; no state changes when low.
REQ-005 din  in  8  CPU write data.
REQ-006 up_dt1, up_tl, up_ks_ar, up_amen_dr, up_sr, up_sl_rr, up_ssgeg  in  1 each  operator register write strobes.
REQ-007 update_op_I, update_op_II, update_op_IV  in  1 each  slot-match selects, one per pipeline stage.
REQ-008 up_keyon  in  1  key-on write strobe; op mask = din[7:4] (bit4=S1, 5=S2, 6=S3, 7=S4); channel = din[2:0].
REQ-009 next_op  in  2  upcoming slot operator (0=S1, 1=S3, 2=S2, 3=S4); next_ch  in  3  upcoming slot channel.
REQ-010 csm, overflow_A  in  1 each  CSM mode and timer-A overflow.
REQ-011 alg_I  in  3  algorithm of current slot.
REQ-012 s1_enters, s2_enters, s3_enters, s4_enters  in  1 each  one-hot current operator.
REQ-013 op_regs  out  44  {tl[6:0], dt1[2:0], mul[3:0], ks[1:0], ar[4:0], amsen, d1r[4:0], d2r[4:0], sl[3:0], rr[3:0], ssg_en, ssg_eg[2:0]}, MSB first.
REQ-014 keyon_I  out  1  key-on state of current slot.
REQ-015 use_prevprev1, use_internal_x, use_internal_y, use_prev2, use_prev1  out  1 each  modulator input selects.

Function
REQ-016 Operator store: circular shift register of 4*NUM_CH stages x 44 bits; shifts one stage per clk_en; op_regs = last stage; the last stage feeds back into the first.
REQ-017 Fields entering stage 0 are replaced by din only when the strobe and the matching select are both high; all other fields recirculate unchanged.
REQ-018 Writes using update_op_I: up_dt1 sets dt1=din[6:4]; up_ks_ar sets ar=din[4:0]; up_amen_dr sets d1r=din[4:0]; up_sr sets d2r=din[4:0]; up_sl_rr sets sl=din[7:4], rr=din[3:0]; up_ssgeg sets ssg_en=din[3], ssg_eg=din[2:0].
REQ-019 Writes using update_op_II: up_dt1 sets mul=din[3:0]; up_ks_ar sets ks=din[7:6].
REQ-020 Writes using update_op_IV: up_tl sets tl=din[6:0]; up_amen_dr sets amsen=din[7].
REQ-021 Key-on store: one bit per slot, circulating in step with (next_op,next_ch).
REQ-022 When up_keyon and next_ch==din[2:0], the slot bit is loaded from the din[7:4] bit selected by next_op; otherwise the bit recirculates.
REQ-023 Channel codes 3 and 7 never match and are ignored; with NUM_CH=3, codes 4-6 are also ignored.
REQ-024 CSM: when csm and overflow_A are high and next_ch==2, the slot bit is forced to 1 for that pass.
REQ-025 CSM has priority over a simultaneous up_keyon.
REQ-026 keyon_I is registered: it shows the bit of the slot presented by next_op/next_ch one clk_en earlier.
REQ-027 Routing is purely combinational, with a=alg_I:
- use_prevprev1 = s1 | (s3 & a==5);
- use_prev2 = (s3 & a<=2) | (s4 & a==3);
- use_internal_x = s4 & a==2;
- use_internal_y = s4 & a<=1;
- use_prev1 = s1 | (s3 & a==1) | (s2 & a in {0,3,4,5,6}) | (s4 & a in {0,5}).

Reset
REQ-028 Reset clears every operator field, every key-on bit and keyon_I to 0.
REQ-029 Reset asserted mid-write discards the write.
REQ-030 The first clk_en after reset release operates normally.

Configuration
REQ-031 Macro JT12_CSM_EN:
- defined: REQ-024/025 apply;
- undefined: csm and overflow_A are ignored and key-on is driven by up_keyon only.

Structure
REQ-032 Shared package jt12_pkg holds the field widths, the 44-bit field layout, the operator order constants (S1=0, S3=1, S2=2, S4=3) and the invalid channel codes.
REQ-033 One sub-module, jt12_op_sh: a parameterised width x stages shift register with asynchronous active-low reset and a reset value parameter; it is used for both stores.

Verification
REQ-034 Routing sweep: alg 0..7 x each sN_enters -> exactly the REQ-027 table (e.g. alg=5 with s3 -> use_prevprev1=1, all others 0).
REQ-035 up_dt1, din=0x57, update_op_I and update_op_II pulsed on the same slot -> after 4*NUM_CH clk_en that slot shows dt1=5, mul=7; other slots remain 0.
REQ-036 up_sl_rr, din=0xA3 on one slot -> sl=0xA, rr=3 there, unchanged elsewhere; a second write with the select low leaves the values intact.
REQ-037 up_keyon, din=0xF1 -> all four slots of channel 1 have keyon_I=1 on their next pass; din=0x01 -> all four return to 0.
REQ-038 Invalid channel: up_keyon, din=0xF3 -> no keyon_I change in any slot.
REQ-039 With JT12_CSM_EN: csm=1, overflow_A=1 -> channel-2 slots read 1; with the macro undefined they stay 0; rst low mid-run -> all outputs 0.
